// File: rtl/dkong_bus_ctrl_if.sv
// ---------------------------------------------------------------------------
// dkong_bus_ctrl_if
// Purpose : groups the Z80-side strobes, video handshake inputs and every
//           decoded select / latch output of dkong_bus_ctrl into one bundle.
// Modports: slave  - the bus controller (drives the O_* outputs)
//           master - the CPU / board side (drives the I_* inputs)
// Signals : I_CEN        CPU-rate enable, one I_CLK wide
//           I_AB, I_DB   CPU address / write data
//           I_MREQ_n, I_RD_n, I_WR_n, I_RFSH_n  Z80 strobes
//           I_VRAMBUSY_n video owns VRAM when low
//           I_VBLK_n     low during vertical blank
//           O_WAIT_n, O_NMI_n                   CPU wait / NMI
//           O_ROM_CS_n, O_RAM_CS_n, O_OBJ_*, O_VRAM_*, O_DMA_CS_n, O_SW_OE_n
//           O_LATCH_Q, O_CMD_Q, O_WAIT_TMO
// ---------------------------------------------------------------------------
interface dkong_bus_ctrl_if #(
  parameter int RAM_BANKS   = 3,
  parameter int SW_PORTS    = 4,
  parameter int LATCH_BANKS = 2,
  parameter int CMD_W       = 4
);
  logic                       I_CEN;
  logic [15:0]                I_AB;
  logic [7:0]                 I_DB;
  logic                       I_MREQ_n;
  logic                       I_RD_n;
  logic                       I_WR_n;
  logic                       I_RFSH_n;
  logic                       I_VRAMBUSY_n;
  logic                       I_VBLK_n;

  logic                       O_WAIT_n;
  logic                       O_NMI_n;
  logic                       O_ROM_CS_n;
  logic [RAM_BANKS-1:0]       O_RAM_CS_n;
  logic                       O_OBJ_RD_n;
  logic                       O_OBJ_WR_n;
  logic                       O_VRAM_RD_n;
  logic                       O_VRAM_WR_n;
  logic                       O_DMA_CS_n;
  logic [SW_PORTS-1:0]        O_SW_OE_n;
  logic [8*LATCH_BANKS-1:0]   O_LATCH_Q;
  logic [CMD_W-1:0]           O_CMD_Q;
  logic                       O_WAIT_TMO;

  modport slave (
    input  I_CEN, I_AB, I_DB, I_MREQ_n, I_RD_n, I_WR_n, I_RFSH_n,
           I_VRAMBUSY_n, I_VBLK_n,
    output O_WAIT_n, O_NMI_n, O_ROM_CS_n, O_RAM_CS_n, O_OBJ_RD_n, O_OBJ_WR_n,
           O_VRAM_RD_n, O_VRAM_WR_n, O_DMA_CS_n, O_SW_OE_n, O_LATCH_Q,
           O_CMD_Q, O_WAIT_TMO
  );

  modport master (
    output I_CEN, I_AB, I_DB, I_MREQ_n, I_RD_n, I_WR_n, I_RFSH_n,
           I_VRAMBUSY_n, I_VBLK_n,
    input  O_WAIT_n, O_NMI_n, O_ROM_CS_n, O_RAM_CS_n, O_OBJ_RD_n, O_OBJ_WR_n,
           O_VRAM_RD_n, O_VRAM_WR_n, O_DMA_CS_n, O_SW_OE_n, O_LATCH_Q,
           O_CMD_Q, O_WAIT_TMO
  );
endinterface

// File: rtl/dkong_bus_ctrl.sv
// ---------------------------------------------------------------------------
// dkong_bus_ctrl
// Purpose : Donkey Kong style CPU bus controller. Decodes the Z80 memory map
//           into chip selects, holds the I/O bit latches and command latch,
//           stretches VRAM accesses with WAIT while video owns VRAM (with a
//           timeout), and generates the vertical-blank NMI.
// Ports   : I_CLK   system clock, all state on its rising edge
//           I_RESET asynchronous active-high reset
//           bus     dkong_bus_ctrl_if.slave (strobes in, selects/latches out)
// Memory map (all qualified by I_RFSH_n=1, I_MREQ_n=0):
//   0000-3FFF ROM, 6000+400h*k RAM bank k, 7000-73FF OBJ, 7400-77FF VRAM,
//   7800-783F DMA, 7C00+80h*k switch port k (read),
//   7C00 command latch (write), 7D80+80h*j bit latch bank j (write).
// ---------------------------------------------------------------------------
module dkong_bus_ctrl #(
  parameter int RAM_BANKS   = 3,
  parameter int SW_PORTS    = 4,
  parameter int LATCH_BANKS = 2,
  parameter int CMD_W       = 4,
  parameter int WAIT_MAX    = 255,
  parameter int NMI_BIT     = 4
) (
  input  logic              I_CLK,
  input  logic              I_RESET,
  dkong_bus_ctrl_if.slave   bus
);

  localparam int               CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
  localparam logic             WAIT_EN  = (WAIT_MAX > 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } wait_state_t;

  wait_state_t                state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       tmo_q, tmo_d;
  logic                       io_wr_q;
  logic                       vblk_q;
  logic                       nmi_n_q, nmi_n_d;
  logic                       wait_exit_q;
  logic [8*LATCH_BANKS-1:0]   latch_q, latch_d;
  logic [CMD_W-1:0]           cmd_q, cmd_d;

  logic                       mem_s, rd_s, wr_s, acc_s;
  logic                       vram_hit_s, vram_acc_s, io_wr_s, io_fire_s;
  logic                       vblk_fall_s, nmi_en_s;
  logic [CNT_W-1:0]           cnt_inc_s;
  logic [RAM_BANKS-1:0]       ram_cs_n_s;
  logic [SW_PORTS-1:0]        sw_oe_n_s;
  logic [15:0]                ab_s;

  assign ab_s       = bus.I_AB;
  assign mem_s      = bus.I_RFSH_n & ~bus.I_MREQ_n;
  assign rd_s       = mem_s & ~bus.I_RD_n;
  assign wr_s       = mem_s & ~bus.I_WR_n;
  assign acc_s      = rd_s | wr_s;
  assign vram_hit_s = (ab_s[15:10] == 6'h1D);
  assign vram_acc_s = acc_s & vram_hit_s;
  assign io_wr_s    = wr_s & (ab_s[15:10] == 6'h1F);
  // A held write strobe only counts on its first active edge.
  assign io_fire_s  = io_wr_s & ~io_wr_q;
  assign vblk_fall_s = vblk_q & ~bus.I_VBLK_n;
  assign nmi_en_s   = latch_q[NMI_BIT];
  assign cnt_inc_s  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Wait FSM next state, wait counter and sticky timeout flag.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (WAIT_EN && bus.I_CEN && vram_acc_s && !bus.I_VRAMBUSY_n && bus.I_VBLK_n) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Video releasing VRAM or vblank starting ends the wait at once.
        if (bus.I_VRAMBUSY_n || !bus.I_VBLK_n) begin
          state_d = ST_IDLE;
        end else if (bus.I_CEN) begin
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == WAIT_LIM) begin
            state_d = ST_HOLD;
            tmo_d   = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        // Stay out of WAIT until the timed-out bus cycle has finished.
        if (bus.I_MREQ_n) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bit latches, command latch and NMI next state.
  always_comb begin
    latch_d = latch_q;
    for (int j = 0; j < LATCH_BANKS; j++) begin
      for (int b = 0; b < 8; b++) begin
        latch_d[8*j+b] = (io_fire_s && (ab_s[15:7] == (9'h0FB + 9'(j))) && (ab_s[2:0] == 3'(b)))
                         ? bus.I_DB[0] : latch_q[8*j+b];
      end
    end
    cmd_d = (io_fire_s && (ab_s[15:7] == 9'h0F8)) ? bus.I_DB[CMD_W-1:0] : cmd_q;
    // A cleared enable wins over a simultaneous vblank edge.
    if (!nmi_en_s) begin
      nmi_n_d = 1'b1;
    end else if (vblk_fall_s) begin
      nmi_n_d = 1'b0;
    end else begin
      nmi_n_d = nmi_n_q;
    end
  end

  // Banked selects: unimplemented banks/ports never match.
  always_comb begin
    ram_cs_n_s = '1;
    sw_oe_n_s  = '1;
    for (int k = 0; k < RAM_BANKS; k++) begin
      ram_cs_n_s[k] = ~(acc_s && (ab_s[15:10] == (6'h18 + 6'(k))));
    end
    for (int k = 0; k < SW_PORTS; k++) begin
      sw_oe_n_s[k] = ~(rd_s && (ab_s[15:7] == (9'h0F8 + 9'(k))));
    end
  end

  // State registers.
  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
      io_wr_q     <= 1'b0;
      vblk_q      <= 1'b1;
      nmi_n_q     <= 1'b1;
      wait_exit_q <= 1'b0;
      latch_q     <= '0;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      io_wr_q     <= io_wr_s;
      vblk_q      <= bus.I_VBLK_n;
      nmi_n_q     <= nmi_n_d;
      wait_exit_q <= (state_q == ST_WAIT);
      latch_q     <= latch_d;
      cmd_q       <= cmd_d;
    end
  end

  assign bus.O_WAIT_n    = (state_q != ST_WAIT);
  assign bus.O_NMI_n     = nmi_n_q;
  assign bus.O_WAIT_TMO  = tmo_q;
  assign bus.O_LATCH_Q   = latch_q;
  assign bus.O_CMD_Q     = cmd_q;
  assign bus.O_ROM_CS_n  = ~(mem_s && (ab_s[15:14] == 2'b00));
  assign bus.O_RAM_CS_n  = ram_cs_n_s;
  assign bus.O_OBJ_RD_n  = ~(rd_s && (ab_s[15:10] == 6'h1C));
  assign bus.O_OBJ_WR_n  = ~(wr_s && (ab_s[15:10] == 6'h1C));
  assign bus.O_VRAM_RD_n = ~(rd_s && vram_hit_s);
  // The write strobe is withheld while stalled and for one clock after.
  assign bus.O_VRAM_WR_n = ~(wr_s && vram_hit_s && (state_q != ST_WAIT) && !wait_exit_q);
  assign bus.O_DMA_CS_n  = ~(acc_s && (ab_s[15:6] == 10'h1E0));
  assign bus.O_SW_OE_n   = sw_oe_n_s;

endmodule
